// File: rtl/countdown_timer_with_load.sv
// Loadable down-counter timer: start/abort handshake, one-shot or periodic expiry.
// state | meaning: IDLE = stopped, count 0 | RUN = counting down on enable | DONE = one-shot expired, holding 0
module countdown_timer_with_load #(
  parameter int MAXIMUM_VALUE     = 36,
  parameter int NBITS_FOR_COUNTER = 6
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         enable,
  input  logic                         auto_reload,
  input  logic [NBITS_FOR_COUNTER-1:0] load_value,
  output logic [NBITS_FOR_COUNTER-1:0] count_out,
  output logic                         busy,
  output logic                         done,
  output logic                         expired
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [NBITS_FOR_COUNTER-1:0] MAX_LOAD = NBITS_FOR_COUNTER'(MAXIMUM_VALUE - 1);

  logic [1:0]                   state_q, state_d;
  logic [NBITS_FOR_COUNTER-1:0] count_q, count_d;
  logic [NBITS_FOR_COUNTER-1:0] shadow_q, shadow_d;
  logic                         reload_q, reload_d;
  logic                         done_q, done_d;
  logic [NBITS_FOR_COUNTER-1:0] load_clamped;

  assign load_clamped = (load_value > MAX_LOAD) ? MAX_LOAD : load_value;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    shadow_d = shadow_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    // abort outranks both a start and a same-cycle expiry
    if (abort) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            count_d  = load_clamped;
            shadow_d = load_clamped;
            reload_d = auto_reload;
            state_d  = ST_RUN;
          end
        end
        ST_RUN: begin
          if (start) begin
            count_d  = load_clamped;
            shadow_d = load_clamped;
            reload_d = auto_reload;
          end else if (enable) begin
            if (count_q != '0) begin
              count_d = count_q - 1'b1;
            end else begin
              done_d = 1'b1;
              if (reload_q) begin
                count_d = shadow_q;
              end else begin
                state_d = ST_DONE;
              end
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      shadow_q <= '0;
      reload_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      shadow_q <= shadow_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  assign count_out = count_q;
  assign busy      = (state_q == ST_RUN);
  assign expired   = (state_q == ST_DONE);
  assign done      = done_q;

endmodule
